// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - counter encodings, entry type and index/tag helpers for branch_predictor
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  // Per-entry state with fixed width; tag and target live in their own parametrised arrays.
  typedef struct packed {
    logic       valid;
    logic [1:0] ctr;
  } bp_entry_t;

  function automatic logic [63:0] bp_index(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int unsigned idx_w,
                                         input int unsigned tag_w);
    return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// rtl/bp_sat_ctr.sv - 2-bit saturating up/down counter next-state function
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters; BP_STATS_EN adds stat counters
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter int         ENTRIES  = 16,
  parameter int         TAG_W    = 8,
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic              bp_flush,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_entry_t         ent_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q [ENTRIES];
  logic [ADDR_W-1:0] tgt_q [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             u_hit, actual_taken;
  logic [1:0]       ctr_d;

  assign f_idx = IDX_W'(bp_index(64'(fetch_pc), IDX_W));
  assign f_tag = TAG_W'(bp_tag(64'(fetch_pc), IDX_W, TAG_W));
  assign u_idx = IDX_W'(bp_index(64'(upd_pc), IDX_W));
  assign u_tag = TAG_W'(bp_tag(64'(upd_pc), IDX_W, TAG_W));

  // Lookup is masked during reset so the PC mux never sees stale entries.
  assign pred_hit    = !rst && ent_q[f_idx].valid && (tag_q[f_idx] == f_tag);
  assign pred_taken  = pred_hit && ent_q[f_idx].ctr[1];
  assign pred_target = pred_taken ? tgt_q[f_idx] : fetch_pc + ADDR_W'(4);

  assign actual_taken = upd_is_branch && upd_taken;
  assign mispredict   = !rst && upd_valid &&
                        ((upd_pred_taken != actual_taken) ||
                         (actual_taken && (upd_pred_target != upd_target)));
  assign redirect_pc  = upd_taken ? upd_target : upd_pc + ADDR_W'(4);

  assign u_hit = ent_q[u_idx].valid && (tag_q[u_idx] == u_tag);

  bp_sat_ctr u_sat_ctr (
    .ctr_i (ent_q[u_idx].ctr),
    .inc_i (upd_taken),
    .ctr_o (ctr_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i].valid <= 1'b0;
        ent_q[i].ctr   <= CTR_INIT;
      end
    end else if (bp_flush) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i].valid <= 1'b0;
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_is_branch) begin
          ent_q[u_idx].ctr <= ctr_d;
          if (upd_taken) tgt_q[u_idx] <= upd_target;
        end else begin
          ent_q[u_idx].valid <= 1'b0;
        end
      end else if (actual_taken) begin
        ent_q[u_idx].valid <= 1'b1;
        ent_q[u_idx].ctr   <= CTR_INIT;
        tag_q[u_idx]       <= u_tag;
        tgt_q[u_idx]       <= upd_target;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (upd_valid && upd_is_branch && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict && (mp_cnt_q != '1)) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign stat_branches    = br_cnt_q;
  assign stat_mispredicts = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor against a table model
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_is_branch, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        bp_flush;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int n_vec = 0;
  int n_err = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .bp_flush(bp_flush),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: 16 entries, index = word address mod 16, tag = next 8 bits.
  bit          m_v [16];
  int unsigned m_t [16];
  logic [31:0] m_g [16];
  int          m_c [16];
  longint unsigned m_br, m_mp;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd16);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return (pc / 32'd64) % 32'd256;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_v[m_idx(pc)] && (m_t[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_c[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_taken(pc) ? m_g[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_misp();
    bit act;
    if (rst || !upd_valid) return 1'b0;
    act = upd_is_branch && upd_taken;
    if (act) return !upd_pred_taken || (upd_pred_target != upd_target);
    return upd_pred_taken;
  endfunction

  function automatic logic [31:0] m_redir();
    return upd_taken ? upd_target : upd_pc + 32'd4;
  endfunction

  task automatic m_commit();
    int i;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin m_v[k] = 0; m_c[k] = 2; end
      m_br = 0; m_mp = 0;
    end else begin
      if (upd_valid && upd_is_branch && m_br < 64'hFFFF_FFFF) m_br++;
      if (m_misp() && m_mp < 64'hFFFF_FFFF) m_mp++;
      if (bp_flush) begin
        for (int k = 0; k < 16; k++) m_v[k] = 0;
      end else if (upd_valid) begin
        i = m_idx(upd_pc);
        if (m_hit(upd_pc)) begin
          if (upd_is_branch) begin
            if (upd_taken) begin
              m_c[i] = (m_c[i] == 3) ? 3 : m_c[i] + 1;
              m_g[i] = upd_target;
            end else begin
              m_c[i] = (m_c[i] == 0) ? 0 : m_c[i] - 1;
            end
          end else begin
            m_v[i] = 0;
          end
        end else if (upd_is_branch && upd_taken) begin
          m_v[i] = 1; m_t[i] = m_tagof(upd_pc); m_g[i] = upd_target; m_c[i] = 2;
        end
      end
    end
  endtask

  task automatic tick();
    m_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd_valid = 0; upd_pc = 0; upd_is_branch = 0; upd_taken = 0; upd_target = 0;
    upd_pred_taken = 0; upd_pred_target = 0; bp_flush = 0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input bit br, input bit tk,
                           input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    upd_valid = 1; upd_pc = pc; upd_is_branch = br; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic test_reset();
    rst = 1; fetch_pc = 32'h40;
    drive_upd(32'h40, 1, 1, 32'h100, 0, 32'h44);
    #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL rst_hit got %0b want 0", pred_hit); end
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_taken got %0b want 0", pred_taken); end
    n_vec++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL rst_target got %h want 00000044", pred_target); end
    n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL rst_mispredict got %0b want 0", mispredict); end
    tick();
    tick();
    rst = 0; idle();
    #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL rst_discard_hit got %0b want 0", pred_hit); end
`ifdef BP_STATS_EN
    n_vec++; if (stat_branches !== 32'd0) begin n_err++; $display("FAIL rst_stat_br got %0d want 0", stat_branches); end
`endif
  endtask

  task automatic test_learn();
    // Update pattern: T (alloc, ctr 2), N, N, T, T, T, T, T, N with expected pred_taken after each
    bit dir [9] = '{1, 0, 0, 1, 1, 1, 1, 1, 0};
    bit exp_tk [9] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
    fetch_pc = 32'h40;
    drive_upd(32'h40, 1, 1, 32'h100, 0, 32'h44);
    #1;
    n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL learn_misp got %0b want 1", mispredict); end
    n_vec++; if (redirect_pc !== 32'h100) begin n_err++; $display("FAIL learn_redir got %h want 00000100", redirect_pc); end
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL same_cycle_hit got %0b want 0", pred_hit); end
    for (int s = 0; s < 9; s++) begin
      drive_upd(32'h40, 1, dir[s], 32'h100, m_taken(32'h40), m_target(32'h40));
      if (s == 0) upd_pred_taken = 0;
      if (s == 0) upd_pred_target = 32'h44;
      tick();
      idle();
      #1;
      n_vec++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL learn_hit[%0d] got %0b want 1", s, pred_hit); end
      n_vec++; if (pred_taken !== exp_tk[s]) begin n_err++; $display("FAIL learn_taken[%0d] got %0b want %0b", s, pred_taken, exp_tk[s]); end
      n_vec++; if (pred_target !== (exp_tk[s] ? 32'h100 : 32'h44)) begin n_err++; $display("FAIL learn_target[%0d] got %h", s, pred_target); end
    end
  endtask

  task automatic test_alias();
    fetch_pc = 32'h440; idle();
    #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL alias_miss got %0b want 0", pred_hit); end
    n_vec++; if (pred_target !== 32'h444) begin n_err++; $display("FAIL alias_target got %h want 00000444", pred_target); end
    drive_upd(32'h440, 1, 1, 32'h200, 0, 32'h444);
    tick(); idle();
    fetch_pc = 32'h40; #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL alias_evict got %0b want 0", pred_hit); end
    fetch_pc = 32'h440; #1;
    n_vec++; if (pred_target !== 32'h200) begin n_err++; $display("FAIL alias_new_target got %h want 00000200", pred_target); end
    drive_upd(32'h440, 0, 0, 32'h0, 0, 32'h444);
    #1;
    n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL nonbr_misp got %0b want 0", mispredict); end
    n_vec++; if (redirect_pc !== 32'h444) begin n_err++; $display("FAIL nonbr_redir got %h want 00000444", redirect_pc); end
    tick(); idle(); #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL nonbr_invalidate got %0b want 0", pred_hit); end
  endtask

  task automatic test_flush();
    drive_upd(32'h40, 1, 1, 32'h100, 0, 32'h44);
    tick();
    drive_upd(32'h80, 1, 1, 32'h300, 0, 32'h84);
    bp_flush = 1; fetch_pc = 32'h80;
    tick(); idle();
    #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL flush_upd_hit got %0b want 0", pred_hit); end
    fetch_pc = 32'h40; #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL flush_old_hit got %0b want 0", pred_hit); end
`ifdef BP_STATS_EN
    n_vec++; if (stat_branches !== 32'(m_br)) begin n_err++; $display("FAIL flush_stat_br got %0d want %0d", stat_branches, m_br); end
`endif
    fetch_pc = 32'hFFFF_FFFF;
    drive_upd(32'hFFFF_FFFF, 1, 0, 32'h0, 0, 32'h3);
    #1;
    n_vec++; if (pred_target !== 32'h3) begin n_err++; $display("FAIL wrap_target got %h want 00000003", pred_target); end
    n_vec++; if (redirect_pc !== 32'h3) begin n_err++; $display("FAIL wrap_redir got %h want 00000003", redirect_pc); end
    tick(); idle();
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 49) == 0) return 32'hFFFF_FFFF;
    return 32'(($urandom_range(0, 2) << 6) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
  endfunction

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      bp_flush = ($urandom_range(0, 39) == 0);
      fetch_pc = rand_pc();
      upd_valid = ($urandom_range(0, 3) != 0);
      upd_pc = rand_pc();
      upd_is_branch = ($urandom_range(0, 4) != 0);
      upd_taken = 1'($urandom_range(0, 1));
      upd_target = 32'(32'h1000 + ($urandom_range(0, 3) << 4));
      if ($urandom_range(0, 2) != 0) begin
        upd_pred_taken = m_taken(upd_pc); upd_pred_target = m_target(upd_pc);
      end else begin
        upd_pred_taken = 1'($urandom_range(0, 1)); upd_pred_target = 32'(32'h1000 + ($urandom_range(0, 3) << 4));
      end
      #1;
      n_vec++; if (pred_hit !== (!rst && m_hit(fetch_pc))) begin n_err++; $display("FAIL rnd_hit[%0d] got %0b", k, pred_hit); end
      n_vec++; if (pred_taken !== (!rst && m_taken(fetch_pc))) begin n_err++; $display("FAIL rnd_taken[%0d] got %0b", k, pred_taken); end
      n_vec++; if (pred_target !== (rst ? fetch_pc + 32'd4 : m_target(fetch_pc))) begin n_err++; $display("FAIL rnd_target[%0d] got %h want %h", k, pred_target, m_target(fetch_pc)); end
      n_vec++; if (mispredict !== m_misp()) begin n_err++; $display("FAIL rnd_misp[%0d] got %0b want %0b", k, mispredict, m_misp()); end
      n_vec++; if (redirect_pc !== m_redir()) begin n_err++; $display("FAIL rnd_redir[%0d] got %h want %h", k, redirect_pc, m_redir()); end
      tick();
    end
    rst = 0; idle();
    #1;
`ifdef BP_STATS_EN
    n_vec++; if (stat_branches !== 32'(m_br)) begin n_err++; $display("FAIL rnd_stat_br got %0d want %0d", stat_branches, m_br); end
    n_vec++; if (stat_mispredicts !== 32'(m_mp)) begin n_err++; $display("FAIL rnd_stat_mp got %0d want %0d", stat_mispredicts, m_mp); end
`endif
  endtask

  initial begin
    rst = 1; fetch_pc = 0; idle();
    test_reset();
    test_learn();
    test_alias();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters, parametrised in address width, entry count and tag width. Sits beside the PC: fetch-stage lookup of the current PC gives a predicted next PC for the PC mux; decode-stage branch resolution updates the table and flags mispredicts to drive the IF/ID flush. It replaces the fixed "predict not-taken, flush on taken" scheme with learned per-branch prediction.

## Interface
- ADDR_W, 32, PC/target width
- ENTRIES, 16, table entries; power of two, 2..256
- TAG_W, 8, tag bits stored per entry
- CTR_INIT, 2'b10, counter value on allocate and reset (weakly taken)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_pc  in  ADDR_W  PC being fetched
- pred_hit  out  1  valid entry with matching tag at fetch_pc
- pred_taken  out  1  pred_hit && counter[1]
- pred_target  out  ADDR_W  stored target if pred_taken, else fetch_pc+4
- upd_valid  in  1  decode stage resolves an instruction this cycle
- upd_pc  in  ADDR_W  PC of the resolving instruction
- upd_is_branch  in  1  instruction is a conditional branch or jump
- upd_taken  in  1  actual direction (jump: 1)
- upd_target  in  ADDR_W  actual taken target
- upd_pred_taken  in  1  prediction carried with the instruction through IF/ID
- upd_pred_target  in  ADDR_W  predicted next PC carried through IF/ID
- bp_flush  in  1  invalidate whole table
- mispredict  out  1  predicted next PC was wrong
- redirect_pc  out  ADDR_W  correct next PC: upd_target if upd_taken, else upd_pc+4

## Operation
- index = pc[2 +: IDX_W], IDX_W = log2(ENTRIES); tag = pc[2+IDX_W +: TAG_W]; pc[1:0] ignored.
- Entry: valid, tag, target[ADDR_W], ctr[2].
- Lookup combinational from fetch_pc.
- mispredict = upd_valid && (upd_pred_taken != actual_taken || (actual_taken && upd_pred_target != upd_target)), actual_taken = upd_is_branch && upd_taken.
- Update when upd_valid, at upd_pc's index:
  - hit, upd_is_branch: ctr += 1 if taken (saturate 3), −= 1 if not (saturate 0); target <= upd_target if taken.
  - hit, !upd_is_branch (alias): valid <= 0.
  - miss, branch taken: allocate/overwrite: valid 1, tag, target, ctr <= CTR_INIT.
  - miss, not taken or non-branch: no write.
- bp_flush: all valid <= 0; takes priority over a same-cycle update.
- Sums (+4, +1) truncate to ADDR_W; fetch_pc = all ones wraps pred_target to 3.

## Timing
- Lookup, mispredict, redirect_pc: zero latency, combinational.
- Update/flush/reset commit on the rising edge; visible to lookup the next cycle. Same-cycle lookup of the index being updated sees old contents.
- rst: all valid 0, all ctr CTR_INIT, tags/targets don't-care; pred_hit 0, pred_taken 0, pred_target = fetch_pc+4 during and after reset. Reset mid-stream discards pending updates; rst overrides bp_flush and update.
- mispredict is meaningful only when upd_valid; it is 0 otherwise, including during rst.

## Configuration
- BP_STATS_EN defined: adds stat_branches and stat_mispredicts outputs, 32 bits each, registered, reset 0, +1 per upd_valid&&upd_is_branch and per mispredict respectively, saturating at 2^32−1, unaffected by bp_flush.
- Undefined: ports and counters absent; the rest is unchanged.

## Structure
- bp_pkg: counter encodings (SNT=0, WNT=1, WT=2, ST=3), entry struct type, index/tag extraction functions.
- One sub-module, bp_sat_ctr: 2-bit saturating up/down counter, used as the next-state function per entry.

## Test plan
- After rst, fetch_pc=0x40 -> pred_hit 0, pred_taken 0, pred_target 0x44.
- Update pc 0x40 taken, target 0x100, pred 0/0x44 -> mispredict 1, redirect 0x100; next cycle fetch 0x40 -> hit, taken, target 0x100.
- Same branch not-taken twice -> ctr 2→1→0, pred_taken 0, target 0x44; two more taken -> ctr 2, predicted taken again; 3 taken saturate at 3.
- Aliasing, ENTRIES=16: pc 0x40 and 0x440 (same index, different tag): lookup 0x440 misses; taken update at 0x440 evicts 0x40 entry.
- Same-cycle fetch_pc=0x40 and first-time allocate at 0x40 -> lookup misses that cycle, hits next.
- bp_flush with simultaneous taken update -> table empty afterwards; with BP_STATS_EN, stat_branches still increments by 1.
